div_clk_chk: RTL and testbench
==============================

Name: div_clk_chk

Overview:
- Receive-side checker for divided clocks produced by the clock dividers in this design (e.g. a divide-by-4 output).
- Samples a divided clock in the fast clock domain and measures its period and high time in fast-clock cycles.
- Declares lock after a run of correct periods, flags mismatches and missing edges, and reconstructs the divider phase count.
- Used on-chip and in benches to confirm a divider output is alive and correct.

Parameters:
DIV, 4, expected divide ratio in clk cycles (integer, >=2)
LOCK_N, 3, consecutive correct periods needed to assert locked (>=1)
CW, 4, width of period/high/phase counters; must satisfy 2^CW > 2*DIV

Ports:
clk  input  1  fast reference clock; all logic on rising edge
rst_n  input  1  synchronous, active-high reset (1 = reset asserted); name kept per codebase convention
div_in  input  1  divided clock under check, synchronous to clk
period_o  output  CW  last measured rise-to-rise period, in clk cycles
period_vld  output  1  one-cycle pulse when period_o updates
high_o  output  CW  last measured high time, in clk cycles
locked  output  1  divider confirmed at ratio DIV
err  output  1  one-cycle pulse on a period mismatch (state TRACK or LOCKED)
tmo  output  1  one-cycle pulse on edge timeout
duty_err  output  1  one-cycle pulse on a duty mismatch (optional feature only)
phase_o  output  CW  recovered phase count: 0 in the cycle after a rise, then +1 per cycle; forced 0 when not locked

Behaviour:
- Reset (rst_n=1 at a clk edge): all outputs 0, state IDLE, cnt=0, hcnt=0, match=0, div_d=0. Reset wins over every other event. Asserting reset mid-operation clears everything at that edge.
- Edge detect: div_d is the registered div_in.
  - rise = div_in & ~div_d.
  - fall = ~div_in & div_d.
- Period counter cnt:
  - on rise: cnt<=0.
  - otherwise: cnt<=cnt+1, saturating at 2^CW-1.
  - Measured period at a rise is P = cnt+1.
  - Example for DIV=4: samples 0,0,1,1,0,0,1,1 give P=4.
- High counter hcnt:
  - on rise: hcnt<=1.
  - else if div_in=1: hcnt<=hcnt+1 (saturating).
  - on fall: high_o<=hcnt.
- States:
  - IDLE: wait for the first rise after reset or timeout. On rise go to TRACK with match=0. No period_o update.
  - TRACK, on rise: period_o<=P and period_vld=1 at the next cycle.
    - If P==DIV: match<=match+1. When match+1==LOCK_N, go to LOCKED and set locked=1.
    - Else: match<=0 and err pulses.
  - LOCKED, on rise: period_o<=P and period_vld pulses.
    - If P!=DIV: err pulses, locked<=0, match<=0, go to TRACK.
- Timeout: in TRACK or LOCKED, if there is no rise and cnt+1 reaches 2*DIV, then tmo pulses, locked<=0, match<=0, state goes to IDLE.
  - period_o and high_o hold their last values.
  - A rise in the same cycle as the timeout condition takes precedence; no tmo is raised.
- A stuck-high or stuck-low div_in produces tmo exactly once, then stays in IDLE.
- Latency: every status output is registered and appears 1 clk after the edge of div_in that causes it.
- phase_o = cnt while locked=1, else 0. For DIV=4 it reproduces the divider's 0,1,2,3 count.

Optional Feature:
- Macro DIV_CLK_CHK_DUTY_EN.
- Defined: in LOCKED, on every fall, if hcnt != DIV/2 (integer division) then duty_err pulses for 1 cycle. locked is not affected.
- Not defined: the duty_err port still exists and is tied to 0; no duty comparison logic is built.

Test Plan:
- Reset held 5 cycles with div_in toggling: all outputs 0 throughout; release, then first rise leaves period_vld=0 (state IDLE to TRACK).
- Clean divide-by-4, 50% duty (DIV=4, LOCK_N=3): period_o=4 with period_vld on each rise after the first; locked=1 one cycle after the 4th rise; phase_o cycles 0,1,2,3; high_o=2.
- Locked, then one period of 5 cycles: err pulses 1 cycle after that rise, locked drops to 0, period_o=5; three more 4-cycle periods re-lock.
- Locked, then div_in held 0: tmo pulses once when cnt+1 reaches 8 (8 cycles after the last rise); locked=0; period_o holds 4; no further tmo.
- Reset asserted mid-lock for 1 cycle: locked, period_o, high_o and phase_o are all 0 at the next cycle; re-lock sequence repeats exactly as in the clean case.
- With DIV_CLK_CHK_DUTY_EN, locked, high time changed to 3 of 4: duty_err pulses on each fall, locked stays 1. Without the macro, the same stimulus gives duty_err=0.

Source files
------------

// File: rtl/div_clk_chk.sv
// Divided-clock checker: measures period/high time, locks, flags errors.
// Optional duty check enabled by defining DIV_CLK_CHK_DUTY_EN.
module div_clk_chk #(
  parameter int DIV    = 4,
  parameter int LOCK_N = 3,
  parameter int CW     = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          div_in,
  output logic [CW-1:0] period_o,
  output logic          period_vld,
  output logic [CW-1:0] high_o,
  output logic          locked,
  output logic          err,
  output logic          tmo,
  output logic          duty_err,
  output logic [CW-1:0] phase_o
);

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    LOCKED
  } state_e;

  localparam logic [CW-1:0] CMAX   = '1;
  localparam logic [CW-1:0] DIV_C  = CW'(DIV);
  localparam logic [CW-1:0] LOCK_C = CW'(LOCK_N);
  localparam logic [CW:0]   TMO_C  = (CW+1)'(2 * DIV);

  state_e        state_q, state_d;
  logic          div_d_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] match_q, match_d;
  logic [CW-1:0] period_q, period_d;
  logic [CW-1:0] high_q, high_d;
  logic          vld_q, vld_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;
  logic          tmo_q, tmo_d;
  logic          rise, fall, tmo_hit;
  logic [CW-1:0] p;

  always_comb begin
    rise    = div_in & ~div_d_q;
    fall    = ~div_in & div_d_q;
    p       = cnt_q + 1'b1;
    tmo_hit = ~rise && (({1'b0, cnt_q} + 1'b1) == TMO_C);

    cnt_d = rise ? '0 : ((cnt_q == CMAX) ? cnt_q : cnt_q + 1'b1);

    hcnt_d = hcnt_q;
    if (rise)
      hcnt_d = CW'(1);
    else if (div_in && hcnt_q != CMAX)
      hcnt_d = hcnt_q + 1'b1;

    high_d   = fall ? hcnt_q : high_q;
    state_d  = state_q;
    match_d  = match_q;
    period_d = period_q;
    vld_d    = 1'b0;
    locked_d = locked_q;
    err_d    = 1'b0;
    tmo_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = TRACK;
          match_d = '0;
        end
      end
      TRACK: begin
        if (rise) begin
          period_d = p;
          vld_d    = 1'b1;
          if (p == DIV_C) begin
            match_d = match_q + 1'b1;
            if (match_q + 1'b1 == LOCK_C) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            match_d = '0;
            err_d   = 1'b1;
          end
        end else if (tmo_hit) begin
          tmo_d    = 1'b1;
          locked_d = 1'b0;
          match_d  = '0;
          state_d  = IDLE;
        end
      end
      LOCKED: begin
        if (rise) begin
          period_d = p;
          vld_d    = 1'b1;
          if (p != DIV_C) begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            match_d  = '0;
            state_d  = TRACK;
          end
        end else if (tmo_hit) begin
          tmo_d    = 1'b1;
          locked_d = 1'b0;
          match_d  = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= IDLE;
      div_d_q  <= 1'b0;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      match_q  <= '0;
      period_q <= '0;
      high_q   <= '0;
      vld_q    <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_d_q  <= div_in;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      match_q  <= match_d;
      period_q <= period_d;
      high_q   <= high_d;
      vld_q    <= vld_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

`ifdef DIV_CLK_CHK_DUTY_EN
  localparam logic [CW-1:0] HALF_C = CW'(DIV / 2);
  logic duty_q, duty_d;

  always_comb begin
    duty_d = (state_q == LOCKED) && fall && (hcnt_q != HALF_C);
  end

  always_ff @(posedge clk) begin
    if (rst_n) duty_q <= 1'b0;
    else       duty_q <= duty_d;
  end

  assign duty_err = duty_q;
`else
  assign duty_err = 1'b0;
`endif

  assign period_o   = period_q;
  assign period_vld = vld_q;
  assign high_o     = high_q;
  assign locked     = locked_q;
  assign err        = err_q;
  assign tmo        = tmo_q;
  assign phase_o    = locked_q ? cnt_q : '0;

endmodule

// File: tb/tb_div_clk_chk.sv
// Directed bench for div_clk_chk, DIV=4 LOCK_N=3 CW=4.
// Expected values are hand-derived from the divide-by-4 waveform.
module tb_div_clk_chk;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       div_in;
  logic [3:0] period_o;
  logic       period_vld;
  logic [3:0] high_o;
  logic       locked;
  logic       err;
  logic       tmo;
  logic       duty_err;
  logic [3:0] phase_o;

  int n_chk = 0;
  int n_err = 0;

  logic       s_vld, s_lock, s_err, s_err2, s_duty;
  logic [3:0] s_per, s_high;

`ifdef DIV_CLK_CHK_DUTY_EN
  localparam logic DUTY_EXP = 1'b1;
`else
  localparam logic DUTY_EXP = 1'b0;
`endif

  div_clk_chk #(.DIV(4), .LOCK_N(3), .CW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .div_in     (div_in),
    .period_o   (period_o),
    .period_vld (period_vld),
    .high_o     (high_o),
    .locked     (locked),
    .err        (err),
    .tmo        (tmo),
    .duty_err   (duty_err),
    .phase_o    (phase_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v);
    div_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int lo, input int hi);
    for (int i = 0; i < lo; i++) begin
      drive(1'b0);
      if (i == 0) begin
        s_duty = duty_err;
        s_high = high_o;
      end
    end
    for (int i = 0; i < hi; i++) begin
      drive(1'b1);
      if (i == 0) begin
        s_vld  = period_vld;
        s_per  = period_o;
        s_lock = locked;
        s_err  = err;
      end
      if (i == 1) s_err2 = err;
    end
  endtask

  initial begin
    int npulse;
    int first;
    rst_n  = 1'b1;
    div_in = 1'b0;

    for (int i = 0; i < 5; i++) begin
      drive(logic'(i & 1));
      check("rst_outs",
            {period_o, period_vld, high_o, locked, err, tmo, duty_err, phase_o},
            '0);
    end
    rst_n = 1'b0;

    cyc(2, 2);
    check("first_rise_vld", s_vld, 0);
    cyc(2, 2);
    check("r2_vld", s_vld, 1);
    check("r2_per", s_per, 4);
    check("r2_lock", s_lock, 0);
    check("r2_err", s_err, 0);
    cyc(2, 2);
    check("r3_lock", s_lock, 0);
    cyc(2, 2);
    check("r4_lock", s_lock, 1);
    check("r4_per", s_per, 4);
    check("phase1", phase_o, 1);
    drive(1'b0);
    check("phase2", phase_o, 2);
    check("high2", high_o, 2);
    drive(1'b0);
    check("phase3", phase_o, 3);
    drive(1'b1);
    check("phase0", phase_o, 0);
    check("lock_vld", period_vld, 1);
    drive(1'b1);
    check("phase1b", phase_o, 1);

    cyc(3, 2);
    check("p5_err", s_err, 1);
    check("p5_lock", s_lock, 0);
    check("p5_per", s_per, 5);
    check("p5_vld", s_vld, 1);
    check("p5_err_pulse", s_err2, 0);
    cyc(2, 2);
    check("rl1_lock", s_lock, 0);
    cyc(2, 2);
    check("rl2_lock", s_lock, 0);
    cyc(2, 2);
    check("rl3_lock", s_lock, 1);

    npulse = 0;
    first  = 0;
    for (int j = 1; j <= 20; j++) begin
      drive(1'b0);
      if (tmo) begin
        npulse++;
        if (first == 0) first = j;
      end
    end
    check("tmo_count", npulse, 1);
    check("tmo_when", first, 7);
    check("tmo_lock", locked, 0);
    check("tmo_per", period_o, 4);
    check("tmo_high", high_o, 2);

    for (int k = 0; k < 4; k++) cyc(2, 2);
    check("relock", s_lock, 1);
    rst_n = 1'b1;
    drive(1'b0);
    check("mid_rst", {locked, period_o, high_o, phase_o}, '0);
    rst_n = 1'b0;
    cyc(2, 2);
    check("mr_r1_vld", s_vld, 0);
    cyc(2, 2);
    check("mr_r2_per", s_per, 4);
    check("mr_r2_lock", s_lock, 0);
    cyc(2, 2);
    check("mr_r3_lock", s_lock, 0);
    cyc(2, 2);
    check("mr_r4_lock", s_lock, 1);

    cyc(2, 3);
    check("dt_lock0", s_lock, 1);
    check("dt_duty0", s_duty, 0);
    cyc(1, 3);
    check("dt_duty1", s_duty, DUTY_EXP);
    check("dt_high1", s_high, 3);
    check("dt_lock1", s_lock, 1);
    check("dt_per1", s_per, 4);
    cyc(1, 3);
    check("dt_duty2", s_duty, DUTY_EXP);
    check("dt_lock2", s_lock, 1);
    drive(1'b0);
    check("dt_duty3", duty_err, DUTY_EXP);
    drive(1'b0);
    check("dt_duty_pulse", duty_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
